// File: rtl/pwm_demod.sv
// -----------------------------------------------------------------------------
// pwm_demod
//   Receive side of a PWM link. Samples an external PWM line and measures the
//   high time and the rise-to-rise period of every cycle. It then recovers the
//   duty code O_PD = round(high / sd) with a restoring divider that produces
//   one quotient bit per clock. Each recovered code is presented with a
//   one-cycle O_valid strobe.
//
//   Optional feature: define PWM_DEMOD_FILTER_EN to add a 3-sample glitch
//   filter after the synchronizer. The pin-to-edge latency then becomes 4 clk.
//   With the macro undefined there is no filter and the latency is 2 clk.
//
// Ports
//   clk         in   1    system clock, rising edge
//   rst_n       in   1    synchronous reset, active low
//   pwm_in      in   1    asynchronous PWM input
//   O_PD        out  TP   recovered duty code, held between updates
//   O_valid     out  1    one-cycle strobe when O_PD / period_err update
//   period_err  out  1    measured period outside PERIOD +/- TOL
//   busy        out  1    divider running
// -----------------------------------------------------------------------------
module pwm_demod #(
  parameter int TP     = 8,
  parameter int N_bit  = 14,
  parameter int sd     = 40,
  parameter int PERIOD = 10000,
  parameter int TOL    = 156
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [TP-1:0] O_PD,
  output logic          O_valid,
  output logic          period_err,
  output logic          busy
);

  localparam int ITW = $clog2(N_bit + 1);
  localparam logic [N_bit-1:0] CNT_MAX  = {N_bit{1'b1}};
  localparam logic [N_bit-1:0] CNT_ONE  = N_bit'(1);
  localparam logic [N_bit-1:0] TO_LIMIT = N_bit'(PERIOD + PERIOD / 4);
  localparam logic [N_bit-1:0] PER_NOM  = N_bit'(PERIOD);
  localparam logic [N_bit-1:0] PER_MIN  = N_bit'(PERIOD - TOL);
  localparam logic [N_bit-1:0] PER_MAX  = N_bit'(PERIOD + TOL);
  localparam logic [N_bit:0]   HALF_SD  = (N_bit + 1)'(sd / 2);
  localparam logic [N_bit:0]   SD_EXT   = (N_bit + 1)'(sd);
  localparam logic [ITW-1:0]   LAST_IT  = ITW'(N_bit);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  // Input path
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_q, lvl_d;
`ifdef PWM_DEMOD_FILTER_EN
  logic [1:0] hist_q, hist_d;
`endif
  logic rise, fall;

  // Measurement
  state_t           state_q, state_d;
  logic [N_bit-1:0] hi_cnt_q, hi_cnt_d;
  logic [N_bit-1:0] per_cnt_q, per_cnt_d;
  logic [N_bit-1:0] hi_inc, per_inc;
  logic             cap, cap_to, cap_err;
  logic [N_bit-1:0] cap_hi, cap_per;

  // Divider and output registers
  logic [N_bit-1:0] quo_q, quo_d;
  logic [N_bit:0]   rem_q, rem_d;
  logic [N_bit:0]   rem_shift;
  logic             quo_bit;
  logic [N_bit:0]   div_sum;
  logic [N_bit-1:0] dividend;
  logic [ITW-1:0]   it_cnt_q, it_cnt_d;
  logic             busy_q, busy_d;
  logic             perr_q, perr_d;
  logic             drop_q, drop_d;
  logic [TP-1:0]    o_pd_q, o_pd_d;
  logic             o_valid_q, o_valid_d;
  logic             period_err_q, period_err_d;

  // ---------------------------------------------------------------------------
  // Synchronizer, optional glitch filter, edge detect.
  // lvl_d is the level the measurement logic treats as current. An edge is
  // lvl_d differing from its registered copy lvl_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
`ifdef PWM_DEMOD_FILTER_EN
    hist_d = {hist_q[0], sync2_q};
    // Only follow the synced line once it has held for three samples.
    if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
      lvl_d = sync2_q;
    end else begin
      lvl_d = lvl_q;
    end
`else
    lvl_d = sync2_q;
`endif
  end

  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM and divider next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    cap       = 1'b0;
    cap_to    = 1'b0;
    cap_hi    = hi_cnt_q;
    cap_per   = per_cnt_q;

    hi_inc  = (hi_cnt_q == CNT_MAX) ? CNT_MAX : hi_cnt_q + CNT_ONE;
    per_inc = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;

    unique case (state_q)
      S_IDLE: begin
        // The first rise only opens a measurement window.
        if (rise) begin
          state_d   = S_HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end
      end
      S_HIGH, S_LOW: begin
        if (rise) begin
          // The rise cycle itself is the first count of the new period.
          cap       = 1'b1;
          state_d   = S_HIGH;
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end else if (per_cnt_q >= TO_LIMIT) begin
          // Static line: report 0% or 100% and start a fresh window.
          cap       = 1'b1;
          cap_to    = 1'b1;
          cap_hi    = lvl_d ? PER_NOM : '0;
          cap_per   = PER_NOM;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = lvl_d ? CNT_ONE : '0;
          state_d   = lvl_d ? S_HIGH : S_LOW;
        end else if (state_q == S_HIGH) begin
          per_cnt_d = per_inc;
          if (fall) begin
            state_d = S_LOW;
          end else begin
            hi_cnt_d = hi_inc;
          end
        end else begin
          per_cnt_d = per_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Rounded dividend, saturated so that a huge high time cannot wrap.
    div_sum  = {1'b0, cap_hi} + HALF_SD;
    dividend = div_sum[N_bit] ? CNT_MAX : div_sum[N_bit-1:0];
    cap_err  = cap_to ? 1'b0 : ((cap_per < PER_MIN) || (cap_per > PER_MAX));

    rem_shift = (rem_q << 1) | {{N_bit{1'b0}}, quo_q[N_bit-1]};
    quo_bit   = (rem_shift >= SD_EXT);

    busy_d       = busy_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    it_cnt_d     = it_cnt_q;
    perr_d       = perr_q;
    drop_d       = drop_q;
    o_pd_d       = o_pd_q;
    o_valid_d    = 1'b0;
    period_err_d = period_err_q;

    if (busy_q) begin
      if (it_cnt_q == LAST_IT) begin
        busy_d       = 1'b0;
        o_valid_d    = 1'b1;
        o_pd_d       = (|quo_q[N_bit-1:TP]) ? {TP{1'b1}} : quo_q[TP-1:0];
        period_err_d = perr_q | drop_q;
        drop_d       = 1'b0;
      end else begin
        rem_d    = quo_bit ? (rem_shift - SD_EXT) : rem_shift;
        quo_d    = {quo_q[N_bit-2:0], quo_bit};
        it_cnt_d = it_cnt_q + 1'b1;
      end
      // A capture arriving while the divider is occupied means the line is
      // malformed. Drop the capture and flag the next reported result.
      if (cap) begin
        drop_d = 1'b1;
      end
    end else if (cap) begin
      busy_d   = 1'b1;
      quo_d    = dividend;
      rem_d    = '0;
      it_cnt_d = '0;
      perr_d   = cap_err;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      lvl_q        <= 1'b0;
`ifdef PWM_DEMOD_FILTER_EN
      hist_q       <= '0;
`endif
      state_q      <= S_IDLE;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      it_cnt_q     <= '0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
      drop_q       <= 1'b0;
      o_pd_q       <= '0;
      o_valid_q    <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      lvl_q        <= lvl_d;
`ifdef PWM_DEMOD_FILTER_EN
      hist_q       <= hist_d;
`endif
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      it_cnt_q     <= it_cnt_d;
      busy_q       <= busy_d;
      perr_q       <= perr_d;
      drop_q       <= drop_d;
      o_pd_q       <= o_pd_d;
      o_valid_q    <= o_valid_d;
      period_err_q <= period_err_d;
    end
  end

  assign O_PD       = o_pd_q;
  assign O_valid    = o_valid_q;
  assign period_err = period_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_demod.sv
// -----------------------------------------------------------------------------
// tb_pwm_demod
//   Self-checking bench for pwm_demod. Stimulus tasks drive the PWM pin and
//   push the expected result of every completed measurement into a
//   scoreboard: the code, the error flag and the cycle on which it must
//   appear. A monitor on the falling clock edge pops each entry when its
//   cycle comes and compares it against the DUT. Any O_valid that does not
//   match an entry is reported as unexpected.
// -----------------------------------------------------------------------------
module tb_pwm_demod;

`ifdef PWM_DEMOD_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int TO_CLK  = 12500;
  localparam int DIV_LAT = 15;

  typedef struct {
    int code;
    int err;
    int at_cyc;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] O_PD;
  logic       O_valid;
  logic       period_err;
  logic       busy;

  pwm_demod dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .O_PD      (O_PD),
    .O_valid   (O_valid),
    .period_err(period_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   edge_cnt   = 0;
  int   checks     = 0;
  int   errors     = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic busy_prev  = 1'b0;
  int   start_edge = 0;
  int   pend_hi    = 0;
  bit   pend_valid = 1'b0;
  int   fall_edge  = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic int exp_code(input int hi);
    int q;
    q = (hi + 20) / 40;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int exp_err(input int per);
    return ((per < 9844) || (per > 10156)) ? 1 : 0;
  endfunction

  task automatic push_exp(input int code, input int err, input int at);
    exp_t e;
    e.code   = code;
    e.err    = err;
    e.at_cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the pin. The DUT sees the rise LAT cycles after the next posedge.
  // That rise closes the open measurement window, if there is one.
  task automatic do_rise();
    int d;
    d = edge_cnt + 1 + LAT;
    if (pend_valid) begin
      push_exp(exp_code(pend_hi), exp_err(d - start_edge), d + DIV_LAT);
    end
    pwm_in     = 1'b1;
    start_edge = d;
    pend_valid = 1'b1;
  endtask

  // Expect a timeout report TO_CLK cycles after the current window opened.
  task automatic timeout_push(input int code);
    int t;
    t = start_edge + TO_CLK;
    push_exp(code, 0, t + DIV_LAT);
    start_edge = t;
  endtask

  task automatic period(input int hi, input int per);
    do_rise();
    pend_hi = hi;
    clocks(hi);
    pwm_in = 1'b0;
    clocks(per - hi);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((sb_q.size() > 0) && (sb_q[0].at_cyc == edge_cnt)) begin
        mon_e = sb_q.pop_front();
        $display("cycle %0d: O_valid=%0d O_PD=%0d period_err=%0d (want %0d/%0d)",
                 edge_cnt, O_valid, O_PD, period_err, mon_e.code, mon_e.err);
        check_val("o_valid", 32'(O_valid), 1);
        check_val("o_pd", 32'(O_PD), mon_e.code);
        check_val("period_err", 32'(period_err), mon_e.err);
        check_val("busy_before_valid", 32'(busy_prev), 1);
        check_val("busy_at_valid", 32'(busy), 0);
      end else if (O_valid !== 1'b0) begin
        $display("cycle %0d: O_valid=%0d O_PD=%0d period_err=%0d (none expected)",
                 edge_cnt, O_valid, O_PD, period_err);
        check_val("unexpected_valid", 32'(O_valid), 0);
      end
    end
    busy_prev = busy;
  end

  initial begin
    clocks(3);
    check_val("rst_o_pd", 32'(O_PD), 0);
    check_val("rst_o_valid", 32'(O_valid), 0);
    check_val("rst_period_err", 32'(period_err), 0);
    check_val("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    clocks(5);

    // Nominal periods, rounding boundaries and period error limits
    period(400, 10000);
    period(400, 10000);
    period(420, 9000);
    period(4000, 10100);
    period(419, 3000);

    // Line held low after a rise: 0% report after the timeout
    do_rise();
    clocks(400);
    pwm_in = 1'b0;
    timeout_push(0);
    pend_hi = 0;
    clocks(TO_CLK + 200 - 400);

    // Line held high: 100% report (code 250) after the timeout
    do_rise();
    timeout_push(250);
    clocks(TO_CLK + 300);
    fall_edge = edge_cnt + 1 + LAT;
    pwm_in    = 1'b0;
    pend_hi   = fall_edge - start_edge;
    clocks(500);

    // Reset in the middle of a high phase
    do_rise();
    clocks(200);
    check_val("sb_empty_pre_reset", sb_q.size(), 0);
    check_val("o_pd_nonzero_pre_reset", 32'(O_PD != 8'd0), 1);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    clocks(1);
    check_val("midrst_o_pd", 32'(O_PD), 0);
    check_val("midrst_o_valid", 32'(O_valid), 0);
    check_val("midrst_period_err", 32'(period_err), 0);
    check_val("midrst_busy", 32'(busy), 0);
    rst_n      = 1'b1;
    pend_valid = 1'b0;
    clocks(100);
    period(400, 2000);

    // 1-clk low glitch inside a 4000-clk high phase
    do_rise();
`ifdef PWM_DEMOD_FILTER_EN
    pend_hi = 4000;
    clocks(2000);
    pwm_in = 1'b0;
    clocks(1);
    pwm_in = 1'b1;
    clocks(1999);
`else
    pend_hi = 2000;
    clocks(2000);
    pwm_in = 1'b0;
    clocks(1);
    do_rise();
    pend_hi = 1999;
    clocks(1999);
`endif
    pwm_in = 1'b0;
    clocks(6000);

    do_rise();
    clocks(40);
    pwm_in = 1'b0;
    clocks(20);
    check_val("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
